nr_div_seq_ctrl: RTL
====================

Name: nr_div_seq_ctrl

Overview:
- Sequencer for a non-restoring division step: one add/subtract-and-shift iteration per clock, instead of the fully unrolled combinational array.
- Accepts a dividend/divisor pair over a valid/ready handshake.
- Runs DW iterations plus one remainder-correction cycle, then holds the quotient and remainder until the consumer takes them.
- Sits between the arithmetic unit's issue logic and its result bus; it handles one operation at a time.

Parameters:
- DW, 4, dividend and quotient width in bits (>=2).
- VW, 2, divisor and remainder width in bits (>=1, VW<=DW).
- Derived PW = VW+2: signed partial-remainder width (local, not overridable).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- dividend  in  DW  unsigned dividend (R_0 role).
- divisor  in  VW  unsigned divisor (D role).
- flush  in  1  synchronous abort; discards any operation in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DW  unsigned quotient.
- remainder  out  VW  unsigned remainder.
- div_by_zero  out  1  result came from a zero divisor.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - quotient=0; remainder=0; div_by_zero=0.
  - Internal P, A, D registers and the counter are all 0.
  - Reset mid-operation discards the operation; no result is produced.
- States and transitions:
  - IDLE: in_ready=1.
    - in_valid && divisor!=0: latch A=dividend, D=divisor, P=0, cnt=DW-1; go to ITER.
    - in_valid && divisor==0: go to DONE with quotient=all ones, remainder=dividend[VW-1:0], div_by_zero=1.
  - ITER, one step per cycle:
    - T = {P[PW-2:0], A[DW-1]}.
    - If P[PW-1]==0 then P <= T - D, else P <= T + D (D zero-extended to PW).
    - A <= {A[DW-2:0], ~newP[PW-1]}.
    - If cnt==0, go to CORR; else cnt <= cnt-1.
  - CORR: always exactly one cycle.
    - If P[PW-1]==1 then P <= P + D.
    - Register quotient=A, remainder=corrected P[VW-1:0], div_by_zero=0.
    - Go to DONE.
  - DONE: out_valid=1; outputs stable while out_valid && !out_ready.
    - out_ready: go to IDLE.
- Latency and throughput:
  - Nonzero divisor: out_valid rises DW+1 edges after the accept edge (DW ITER cycles, 1 CORR cycle). The latency is fixed and does not depend on the data.
  - Zero divisor: out_valid rises 1 edge after the accept edge.
  - in_ready is low in ITER, CORR and DONE, so there is no back-to-back accept. Minimum spacing between accepts is DW+3 cycles.
- Arithmetic:
  - All operands are unsigned.
  - P is two's complement PW bits; it never overflows for VW-bit divisors.
  - Quotient digit is 1 when the new P is non-negative.
  - The final result satisfies dividend == quotient*divisor + remainder and remainder < divisor.
- flush:
  - Any state goes to IDLE on the next edge.
  - out_valid drops and output registers keep their values.
  - flush has priority over in_valid and out_ready in the same cycle.
  - flush in IDLE with in_valid high: no accept.
- Simultaneous events:
  - out_valid && out_ready in DONE returns to IDLE. The next accept is possible one cycle later, not in the same cycle.
- Idle activity: quotient/remainder/div_by_zero hold their last result while IDLE. Consumers qualify them with out_valid.

Test Plan:
1. DW=4/VW=2, dividend=13, divisor=3, out_ready=1 -> out_valid rises 5 edges after accept; quotient=4, remainder=1, div_by_zero=0.
2. Sweep all 16x3 nonzero operand pairs back-to-back -> every result matches integer / and %; accept spacing is >=7 cycles; in_ready=0 whenever busy=1.
3. dividend=9, divisor=0 -> out_valid 1 edge after accept; quotient=4'hF, remainder=2'b01, div_by_zero=1.
4. dividend=2, divisor=3, out_ready held 0 for 10 cycles -> quotient=0, remainder=2 held stable with out_valid=1 throughout; return to IDLE on the cycle after out_ready=1.
5. dividend=15, divisor=1; flush on the 2nd ITER cycle, then a new op 7/2 -> no out_valid for the aborted op; second result quotient=3, remainder=1.
6. rst_n pulsed low asynchronously (between edges) mid-ITER -> all outputs return immediately to reset values; in_ready=1 and busy=0 on release; the next op 14/3 gives quotient=4, remainder=2.

Source files
------------

// File: rtl/nr_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential non-restoring divider.
// slave = divider side, master = issue/consumer side.
interface nr_div_seq_ctrl_if #(
  parameter int DW = 4,
  parameter int VW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          busy;

  modport slave (
    input  in_valid, dividend, divisor, flush, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport master (
    output in_valid, dividend, divisor, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/nr_div_seq_ctrl.sv
// Sequential non-restoring divider: one add/sub-and-shift step per clock,
// DW steps plus one remainder-correction cycle, result held until taken.
module nr_div_seq_ctrl #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  nr_div_seq_ctrl_if.slave    bus
);
  // Signed partial remainder: two guard bits above the divisor width.
  localparam int PW = VW + 2;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_CORR, S_DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_p;
  logic [DW-1:0] r_a;
  logic [VW-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_dbz;

  logic [PW-1:0] w_t;
  logic [PW-1:0] w_dx;
  logic [PW-1:0] w_p_step;
  logic [DW-1:0] w_a_step;
  logic [PW-1:0] w_p_corr;

  // One iteration: shift next dividend bit into P, add or subtract D by
  // the sign of the old P; quotient digit is 1 when the new P is >= 0.
  always_comb begin
    w_dx     = {{(PW-VW){1'b0}}, r_d};
    w_t      = {r_p[PW-2:0], r_a[DW-1]};
    w_p_step = r_p[PW-1] ? (w_t + w_dx) : (w_t - w_dx);
    w_a_step = {r_a[DW-2:0], ~w_p_step[PW-1]};
    w_p_corr = r_p[PW-1] ? (r_p + w_dx) : r_p;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_a         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything; result registers keep their values.
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.divisor != '0) begin
              r_a     <= bus.dividend;
              r_d     <= bus.divisor;
              r_p     <= '0;
              r_cnt   <= CW'(DW-1);
              r_state <= S_ITER;
            end else begin
              // Zero divisor short-circuits straight to a flagged result.
              r_q         <= '1;
              r_r         <= bus.dividend[VW-1:0];
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_ITER: begin
          r_p <= w_p_step;
          r_a <= w_a_step;
          if (r_cnt == '0) r_state <= S_CORR;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_CORR: begin
          r_p         <= w_p_corr;
          r_q         <= r_a;
          r_r         <= w_p_corr[VW-1:0];
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule
